// File: rtl/io_out_fifo_pkg.sv
// Shared constants and helpers for the processor I/O queues.
// Default word/address sizing and the {addr,data} entry layout.
package io_out_fifo_pkg;

    localparam int NUBITS_DEF = 16;
    localparam int NUIOOU_DEF = 2;
    localparam int FDEPTH_DEF = 8;
    localparam int DCNTW_DEF  = 8;

    // Address width never collapses to zero, even for a single output port.
    function automatic int io_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int io_lvlw(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int AW_DEF = io_aw(NUIOOU_DEF);

    typedef struct packed {
        logic [AW_DEF-1:0]     addr;
        logic [NUBITS_DEF-1:0] data;
    } io_entry_t;

endpackage

// File: rtl/io_fifo_mem.sv
// Dual-port register array for the I/O queues.
// Writes are synchronous; the read port is combinational so the head falls through.
module io_fifo_mem #(
    parameter int NADDRE = 8,
    parameter int NBDATA = 17
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [$clog2(NADDRE)-1:0] i_waddr,
    input  logic [NBDATA-1:0]         i_wdata,
    input  logic [$clog2(NADDRE)-1:0] i_raddr,
    output logic [NBDATA-1:0]         o_rdata
);

    logic [NBDATA-1:0] r_mem [NADDRE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Output-port buffer behind the processor write path: queues {addr,data} per write,
// drains over valid/ready, and flags/counts writes dropped while full.
module io_out_fifo
    import io_out_fifo_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int FDEPTH = FDEPTH_DEF,
    parameter int DCNTW  = DCNTW_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              out_en,
    input  logic [io_aw(NUIOOU)-1:0]          addr_out,
    input  logic [NUBITS-1:0]                 io_out,
    output logic                              m_valid,
    output logic [io_aw(NUIOOU)-1:0]          m_addr,
    output logic [NUBITS-1:0]                 m_data,
    input  logic                              m_ready,
    output logic [io_lvlw(FDEPTH)-1:0]        level,
    output logic                              full,
    output logic                              ovf,
    output logic [DCNTW-1:0]                  drop_cnt,
    input  logic                              ovf_clr
);

    localparam int AW   = io_aw(NUIOOU);
    localparam int LVLW = io_lvlw(FDEPTH);
    localparam int PW   = $clog2(FDEPTH);
    localparam int EW   = AW + NUBITS;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LVLW-1:0]  r_level;
    logic             r_ovf;
    logic [DCNTW-1:0] r_drop_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic [EW-1:0]    w_rd_entry;

    assign m_valid = (r_level != '0);
    assign w_full  = (r_level == LVLW'(FDEPTH));
    assign w_pop   = m_valid & m_ready;
    // A pop on the same edge frees a slot, so a write to a full queue is still taken.
    assign w_push  = out_en & (~w_full | w_pop);
    assign w_drop  = out_en & w_full & ~w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_level <= r_level + LVLW'(w_push) - LVLW'(w_pop);
        end
    end

    // Clear wins over a coincident drop; that drop goes uncounted by design.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    io_fifo_mem #(
        .NADDRE (FDEPTH),
        .NBDATA (EW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({addr_out, io_out}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    assign m_addr   = w_rd_entry[EW-1:NUBITS];
    assign m_data   = w_rd_entry[NUBITS-1:0];
    assign level    = r_level;
    assign full     = w_full;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
